// File: rtl/alu_seq_muldiv.sv
// EX-stage ALU: registered single-cycle ops plus iterative multiply/divide into HI/LO.
// Define ALU_SIGNED_MD_EN to enable the signed MULT (1110) and DIV (1111) opcodes.
module alu_seq_muldiv #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [3:0]             alu_operation_i,
  input  logic [DATA_WIDTH-1:0]  a_i,
  input  logic [DATA_WIDTH-1:0]  b_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  output logic                   done_o,
  output logic [DATA_WIDTH-1:0]  alu_data_o,
  output logic                   zero_o,
  output logic [DATA_WIDTH-1:0]  hi_o,
  output logic [DATA_WIDTH-1:0]  lo_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_LUI   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1000;
  localparam logic [3:0] OP_PASS  = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_MFHI  = 4'b1100;
  localparam logic [3:0] OP_MFLO  = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [W-1:0]    r_acc_hi;
  logic [W-1:0]    r_acc_lo;
  logic [W-1:0]    r_opnd;
  logic [CW-1:0]   r_cnt;
  logic            r_is_div;
  logic            r_neg_q;
  logic            r_neg_r;

  logic            r_done;
  logic [W-1:0]    r_data;
  logic            r_zero;
  logic [W-1:0]    r_hi;
  logic [W-1:0]    r_lo;

  logic            w_accept;
  logic            w_is_mul;
  logic            w_is_div;
  logic            w_signed;
  logic            w_conv;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [W-1:0]    w_a_mag;
  logic [W-1:0]    w_b_mag;
  logic [W-1:0]    w_sc_result;
  logic [W:0]      w_mul_sum;
  logic [W:0]      w_div_shift;
  logic [W:0]      w_div_diff;
  logic            w_div_ok;
  logic [2*W-1:0]  w_prod;
  logic [W-1:0]    w_fin_hi;
  logic [W-1:0]    w_fin_lo;

  // Opcode decode for the iterative unit.
`ifdef ALU_SIGNED_MD_EN
  localparam logic [3:0] OP_MULT = 4'b1110;
  localparam logic [3:0] OP_DIV  = 4'b1111;
  assign w_is_mul = (alu_operation_i == OP_MULTU) || (alu_operation_i == OP_MULT);
  assign w_is_div = (alu_operation_i == OP_DIVU)  || (alu_operation_i == OP_DIV);
  assign w_signed = (alu_operation_i == OP_MULT)  || (alu_operation_i == OP_DIV);
`else
  assign w_is_mul = (alu_operation_i == OP_MULTU);
  assign w_is_div = (alu_operation_i == OP_DIVU);
  assign w_signed = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) && valid_i;

  // Signed divide by zero keeps the raw bit patterns so it matches DIVU exactly.
  assign w_conv  = w_signed && !(w_is_div && (b_i == '0));
  assign w_a_neg = w_conv && a_i[W-1];
  assign w_b_neg = w_conv && b_i[W-1];
  assign w_a_mag = w_a_neg ? (-a_i) : a_i;
  assign w_b_mag = w_b_neg ? (-b_i) : b_i;

  always_comb begin
    w_sc_result = '0;
    case (alu_operation_i)
      OP_SUB:  w_sc_result = a_i - b_i;
      OP_OR:   w_sc_result = a_i | b_i;
      OP_ADD:  w_sc_result = a_i + b_i;
      OP_LUI:  w_sc_result = {b_i[W/2-1:0], {(W/2){1'b0}}};
      OP_SLL:  w_sc_result = b_i << shamt_i;
      OP_SRL:  w_sc_result = b_i >> shamt_i;
      OP_AND:  w_sc_result = a_i & b_i;
      OP_NOR:  w_sc_result = ~(a_i | b_i);
      OP_PASS: w_sc_result = a_i;
      OP_MFHI: w_sc_result = r_hi;
      OP_MFLO: w_sc_result = r_lo;
      default: w_sc_result = '0;
    endcase
  end

  // Multiply: acc_lo holds the multiplier and collects low product bits as it shifts out.
  assign w_mul_sum   = {1'b0, r_acc_hi} + {1'b0, (r_acc_lo[0] ? r_opnd : {W{1'b0}})};
  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  assign w_div_shift = {r_acc_hi, r_acc_lo[W-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
  assign w_div_ok    = !w_div_diff[W];

  always_comb begin
    w_prod   = {r_acc_hi, r_acc_lo};
    w_fin_hi = '0;
    w_fin_lo = '0;
    if (r_is_div) begin
      w_fin_lo = r_neg_q ? (-r_acc_lo) : r_acc_lo;
      w_fin_hi = r_neg_r ? (-r_acc_hi) : r_acc_hi;
    end else begin
      if (r_neg_q) w_prod = -w_prod;
      w_fin_hi = w_prod[2*W-1:W];
      w_fin_lo = w_prod[W-1:0];
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // FSM: next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul)      w_next_state = S_MUL;
        else if (w_accept && w_is_div) w_next_state = S_DIV;
      end
      S_MUL, S_DIV: if (r_cnt == '0) w_next_state = S_FIN;
      S_FIN:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ready_o = (r_state == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opnd   <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && (w_is_mul || w_is_div)) begin
            r_acc_hi <= '0;
            r_acc_lo <= w_is_div ? w_a_mag : w_b_mag;
            r_opnd   <= w_is_div ? w_b_mag : w_a_mag;
            r_cnt    <= CW'(W - 1);
            r_is_div <= w_is_div;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
          end
        end
        S_MUL: begin
          r_acc_hi <= w_mul_sum[W:1];
          r_acc_lo <= {w_mul_sum[0], r_acc_lo[W-1:1]};
          r_cnt    <= r_cnt - 1'b1;
        end
        S_DIV: begin
          r_acc_hi <= w_div_ok ? w_div_diff[W-1:0] : w_div_shift[W-1:0];
          r_acc_lo <= {r_acc_lo[W-2:0], w_div_ok};
          r_cnt    <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done <= 1'b0;
      r_data <= '0;
      r_zero <= 1'b1;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_FIN) begin
        r_hi   <= w_fin_hi;
        r_lo   <= w_fin_lo;
        r_data <= w_fin_lo;
        r_zero <= (w_fin_lo == '0);
        r_done <= 1'b1;
      end else if (w_accept && !(w_is_mul || w_is_div)) begin
        r_data <= w_sc_result;
        r_zero <= (w_sc_result == '0);
        r_done <= 1'b1;
      end
    end
  end

  assign done_o     = r_done;
  assign alu_data_o = r_data;
  assign zero_o     = r_zero;
  assign hi_o       = r_hi;
  assign lo_o       = r_lo;

endmodule
